// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response channel.
//   imem_req_o   : fetch request valid (driven by the fetch stage)
//   imem_addr_o  : word-aligned fetch address (driven by the fetch stage)
//   imem_ready_i : memory returns data this cycle (driven by the memory)
//   imem_data_i  : instruction word, valid when imem_ready_i=1 (driven by the memory)
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_data_i
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, issues requests to a
// variable-latency instruction memory and presents {instr, PC+4} to IF/ID.
// A one-entry skid buffer (HOLD) keeps a returned word across a stall, and
// a DRAIN state lets an abandoned request complete before refetching.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   PCwrite               : 1 = advance, 0 = stall
//   branch_taken_i/target : branch redirect (wins over jump)
//   jump_i/jump_target_i  : jump redirect
//   imem                  : instruction-memory channel (fetch_stage_if.master)
//   instr_o, increment_4_o, instr_valid_o : IF/ID payload (registered)
//   fetch_cnt_o, bubble_cnt_o : delivered instruction / bubble counters
// Optional feature: define FETCH_PERF_CNT_EN to build the saturating
// counters; otherwise both counter ports drive 0.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 PCwrite,
    input  logic                 branch_taken_i,
    input  logic [31:0]          branch_target_i,
    input  logic                 jump_i,
    input  logic [31:0]          jump_target_i,
    fetch_stage_if.master        imem,
    output logic [31:0]          instr_o,
    output logic [31:0]          increment_4_o,
    output logic                 instr_valid_o,
    output logic [31:0]          fetch_cnt_o,
    output logic [31:0]          bubble_cnt_o
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   drain_addr_q, drain_addr_d;
    logic [XLEN-1:0]   skid_q, skid_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   inc4_q, inc4_d;
    logic              valid_q, valid_d;
    logic              deliver_valid;
    logic              deliver_bubble;
    logic              redirect;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus4;

    // Request depends only on state; reset gates it so nothing is issued
    // while rst_i is held.
    assign imem.imem_req_o  = !rst_i && (state_q != HOLD);
    assign imem.imem_addr_o = (state_q == DRAIN) ? drain_addr_q : pc_q;

    assign instr_o       = instr_q;
    assign increment_4_o = inc4_q;
    assign instr_valid_o = valid_q;

    // Next-state, PC and IF/ID payload.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drain_addr_d   = drain_addr_q;
        skid_d         = skid_q;
        instr_d        = instr_q;
        inc4_d         = inc4_q;
        valid_d        = valid_q;
        deliver_valid  = 1'b0;
        deliver_bubble = 1'b0;
        redirect       = branch_taken_i | jump_i;
        target         = branch_taken_i ? branch_target_i : jump_target_i;
        pc_plus4       = pc_q + XLEN'(4);

        if (redirect) begin
            // Redirect beats a stall; an in-flight request must still finish.
            pc_d           = target & 32'hFFFF_FFFC;
            deliver_bubble = 1'b1;
            case (state_q)
                FETCH: begin
                    if (!imem.imem_ready_i) begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end
                HOLD:    state_d = FETCH;
                DRAIN:   if (imem.imem_ready_i) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem.imem_ready_i && PCwrite) begin
                        deliver_valid = 1'b1;
                        instr_d       = imem.imem_data_i;
                        inc4_d        = pc_plus4;
                        pc_d          = pc_plus4;
                    end else if (imem.imem_ready_i) begin
                        skid_d  = imem.imem_data_i;
                        state_d = HOLD;
                    end else if (PCwrite) begin
                        deliver_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (PCwrite) begin
                        deliver_valid = 1'b1;
                        instr_d       = skid_q;
                        inc4_d        = pc_plus4;
                        pc_d          = pc_plus4;
                        state_d       = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.imem_ready_i) state_d = FETCH;
                    if (PCwrite) deliver_bubble = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end

        if (deliver_bubble) begin
            instr_d = '0;
            inc4_d  = '0;
            valid_d = 1'b0;
        end else if (deliver_valid) begin
            valid_d = 1'b1;
        end
    end

    // State and payload registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            skid_q       <= '0;
            instr_q      <= '0;
            inc4_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            skid_q       <= skid_d;
            instr_q      <= instr_d;
            inc4_q       <= inc4_d;
            valid_q      <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating delivered-instruction / bubble counters.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (deliver_valid && !deliver_bubble && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + XLEN'(1);
        end
        if (deliver_bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign fetch_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a transaction-level
// reference model and hand-computed literal expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcw = 1'b1;
    logic        br  = 1'b0;
    logic        jp  = 1'b0;
    logic        rdy = 1'b1;
    logic [31:0] bt  = '0;
    logic [31:0] jt  = '0;
    logic [31:0] instr, inc4, fcnt, bcnt;
    logic        valid;

    int n_pass  = 0;
    int n_total = 0;

    fetch_stage_if imem ();

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h13;
    endfunction

    assign imem.imem_ready_i = rdy;
    assign imem.imem_data_i  = rdy ? memword(imem.imem_addr_o) : 32'hDEAD_BEEF;

    fetch_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .PCwrite         (pcw),
        .branch_taken_i  (br),
        .branch_target_i (bt),
        .jump_i          (jp),
        .jump_target_i   (jt),
        .imem            (imem.master),
        .instr_o         (instr),
        .increment_4_o   (inc4),
        .instr_valid_o   (valid),
        .fetch_cnt_o     (fcnt),
        .bubble_cnt_o    (bcnt)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a fetcher either owes a word (m_hold), is waiting out
    // an abandoned address (m_drain), or is fetching at m_pc.
    logic        m_hold = 1'b0, m_drain = 1'b0, m_valid = 1'b0;
    logic [31:0] m_pc = '0, m_word = '0, m_drain_addr = '0;
    logic [31:0] m_instr = '0, m_inc = '0, m_fcnt = '0, m_bcnt = '0;

    always @(posedge clk) begin
        logic dv, db;
        logic [31:0] tgt;
        dv = 1'b0;
        db = 1'b0;
        if (rst) begin
            m_hold = 0; m_drain = 0; m_valid = 0; m_pc = 32'h0;
            m_instr = 0; m_inc = 0; m_fcnt = 0; m_bcnt = 0;
        end else begin
            if (br || jp) begin
                tgt = br ? bt : jt;
                if (!m_hold && !m_drain && !rdy) begin
                    m_drain = 1; m_drain_addr = m_pc;
                end else if (m_drain && rdy) begin
                    m_drain = 0;
                end
                m_hold = 0;
                m_pc = {tgt[31:2], 2'b00};
                db = 1;
            end else if (m_drain) begin
                if (rdy) m_drain = 0;
                db = pcw;
            end else if (m_hold) begin
                if (pcw) begin
                    m_hold = 0; m_instr = m_word; m_inc = m_pc + 32'd4;
                    m_pc = m_pc + 32'd4; dv = 1;
                end
            end else if (rdy) begin
                if (pcw) begin
                    m_instr = memword(m_pc); m_inc = m_pc + 32'd4;
                    m_pc = m_pc + 32'd4; dv = 1;
                end else begin
                    m_hold = 1; m_word = memword(m_pc);
                end
            end else begin
                db = pcw;
            end
            if (db) begin
                m_instr = 0; m_inc = 0; m_valid = 0;
                if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
            end
            if (dv) begin
                m_valid = 1;
                if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        logic exp_req;
        exp_req = !rst && !m_hold;
        check32("m_req", 32'(imem.imem_req_o), 32'(exp_req));
        if (exp_req) check32("m_addr", imem.imem_addr_o, m_drain ? m_drain_addr : m_pc);
        check32("m_instr", instr, m_instr);
        check32("m_inc4", inc4, m_inc);
        check32("m_valid", 32'(valid), 32'(m_valid));
`ifdef FETCH_PERF_CNT_EN
        check32("m_fcnt", fcnt, m_fcnt);
        check32("m_bcnt", bcnt, m_bcnt);
`else
        check32("m_fcnt", fcnt, 32'h0);
        check32("m_bcnt", bcnt, 32'h0);
`endif
    end

    task automatic cyc(input logic r, input logic p);
        rdy = r;
        pcw = p;
        @(posedge clk);
        #1;
        br = 1'b0;
        jp = 1'b0;
    endtask

    task automatic do_reset(input logic r);
        rst = 1'b1; br = 1'b0; jp = 1'b0; pcw = 1'b1; rdy = r;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_f, exp_b;
        logic [9:0]  pat;

        // Reset state
        @(posedge clk); #1;
        check32("rst_valid", 32'(valid), 32'h0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_inc4", inc4, 32'h0);
        check32("rst_req", 32'(imem.imem_req_o), 32'h0);
        rst = 1'b0;

        // Zero-wait streaming
        for (int i = 0; i < 4; i++) begin
            check32("zw_addr", imem.imem_addr_o, 32'(i * 4));
            cyc(1'b1, 1'b1);
            check32("zw_inc4", inc4, 32'(i * 4 + 4));
            check32("zw_valid", 32'(valid), 32'h1);
        end

        // Wait states at address 8
        do_reset(1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (2) begin
            cyc(1'b0, 1'b1);
            check32("ws_valid", 32'(valid), 32'h0);
            check32("ws_instr", instr, 32'h0);
            check32("ws_addr", imem.imem_addr_o, 32'h8);
        end
        cyc(1'b1, 1'b1);
        check32("ws_instr8", instr, memword(32'h8));
        check32("ws_inc4", inc4, 32'hC);

        // Stall with returned data -> HOLD
        do_reset(1'b1);
        cyc(1'b1, 1'b1);
        check32("hold_addr", imem.imem_addr_o, 32'h4);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check32("hold_req", 32'(imem.imem_req_o), 32'h0);
        check32("hold_inc4", inc4, 32'h4);
        cyc(1'b1, 1'b1);
        check32("hold_instr4", instr, memword(32'h4));
        check32("hold_inc4b", inc4, 32'h8);
        check32("hold_next", imem.imem_addr_o, 32'h8);

        // Redirect while request outstanding -> DRAIN
        do_reset(1'b1);
        repeat (3) cyc(1'b1, 1'b1);
        br = 1'b1; bt = 32'h40;
        cyc(1'b0, 1'b1);
        check32("dr_valid", 32'(valid), 32'h0);
        check32("dr_addr", imem.imem_addr_o, 32'hC);
        cyc(1'b0, 1'b1);
        check32("dr_addr2", imem.imem_addr_o, 32'hC);
        cyc(1'b1, 1'b1);
        check32("dr_discard", 32'(valid), 32'h0);
        check32("dr_tgt", imem.imem_addr_o, 32'h40);
        cyc(1'b1, 1'b1);
        check32("dr_instr", instr, memword(32'h40));
        check32("dr_inc4", inc4, 32'h44);

        // Branch beats jump, target alignment, PC wrap
        br = 1'b1; bt = 32'h83; jp = 1'b1; jt = 32'h100;
        cyc(1'b1, 1'b1);
        check32("prio_addr", imem.imem_addr_o, 32'h80);
        check32("prio_valid", 32'(valid), 32'h0);
        jp = 1'b1; jt = 32'hFFFF_FFFC;
        cyc(1'b1, 1'b1);
        check32("wrap_addr", imem.imem_addr_o, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b1);
        check32("wrap_inc4", inc4, 32'h0);
        check32("wrap_valid", 32'(valid), 32'h1);
        check32("wrap_next", imem.imem_addr_o, 32'h0);

        // Redirect from HOLD, and repeated redirects inside DRAIN
        cyc(1'b1, 1'b0);
        jp = 1'b1; jt = 32'h200;
        cyc(1'b0, 1'b0);
        check32("hj_addr", imem.imem_addr_o, 32'h200);
        check32("hj_req", 32'(imem.imem_req_o), 32'h1);
        br = 1'b1; bt = 32'h300;
        cyc(1'b0, 1'b0);
        br = 1'b1; bt = 32'h400;
        cyc(1'b0, 1'b0);
        check32("dd_addr", imem.imem_addr_o, 32'h200);
        br = 1'b1; bt = 32'h500;
        cyc(1'b1, 1'b0);
        check32("dd_tgt", imem.imem_addr_o, 32'h500);
        cyc(1'b1, 1'b1);
        check32("dd_instr", instr, memword(32'h500));

        // Reset in the middle of an outstanding request
        cyc(1'b0, 1'b1);
        do_reset(1'b0);
        check32("mr_valid", 32'(valid), 32'h0);
        check32("mr_addr", imem.imem_addr_o, 32'h0);

        // Counters: 10 cycles, 3 bubbles
        do_reset(1'b1);
        pat = 10'b1101101101;
        for (int i = 9; i >= 0; i--) cyc(pat[i], 1'b1);
`ifdef FETCH_PERF_CNT_EN
        exp_f = 32'd7; exp_b = 32'd3;
`else
        exp_f = 32'd0; exp_b = 32'd0;
`endif
        check32("cnt_fetch", fcnt, exp_f);
        check32("cnt_bubble", bcnt, exp_b);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
